regfile_nxw: RTL
================

// Module: regfile_nxw
// PURPOSE
//  Parametrised register file: NREGS x WIDTH storage, one synchronous write port, two async read ports.
//  Write enables come from a parametrised ADDR_W:NREGS one-hot decoder with enable, the generalised 3:8 tree.
//  Optional hard-wired zero register and optional write-to-read bypass.
//  Sits in the datapath between instruction decode (register indices) and the ALU operand muxes.
// PARAMETERS
//  WIDTH    64  data width of each register, in bits
//  NREGS    32  number of registers; must be a power of 2 and at least 2
//  ADDR_W   $clog2(NREGS)  register index width (derived; do not override)
//  ZERO_REG 1   1: register NREGS-1 always reads 0 and ignores writes; 0: it is an ordinary register
//  BYPASS   0   1: a read of the register being written this cycle returns WriteData; 0: it returns the stored value
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  reset          in   1       asynchronous, active-high; clears every register
//  RegWrite       in   1       write enable
//  WriteRegister  in   ADDR_W  write index
//  WriteData      in   WIDTH   write data
//  ReadRegister1  in   ADDR_W  read index, port 1
//  ReadRegister2  in   ADDR_W  read index, port 2
//  ReadData1      out  WIDTH   read data, port 1
//  ReadData2      out  WIDTH   read data, port 2
// BEHAVIOUR
//  - Reset: while reset=1, every register is 0, so ReadData1 = ReadData2 = 0 for any index.
//    Reset asserted mid-cycle clears immediately without waiting for clk.
//    A write whose posedge coincides with reset=1 is discarded.
//  - Write: on posedge clk with RegWrite=1, reg[WriteRegister] <= WriteData. Latency is 1 cycle.
//    Exactly one register is enabled, via decoder out[WriteRegister].
//    RegWrite=0 gives an all-zero decoder output, and no register changes.
//  - Read: combinational, with no clock. ReadDataN = reg[ReadRegisterN].
//    Both ports may address the same register in the same cycle; both return the same value.
//  - ZERO_REG=1:
//    - Reads of index NREGS-1 return 0 on both ports.
//    - A write to NREGS-1 is accepted by the decoder, but the storage is a constant 0 and does not change.
//    - The zero-register rule takes priority over bypass: the read still returns 0.
//  - BYPASS=1: if RegWrite=1 and ReadRegisterN == WriteRegister (and that index is not the zero register),
//    then ReadDataN = WriteData in the same cycle.
//  - BYPASS=0: the same case returns the old value until the posedge, and the new value after it.
//  - Index arithmetic: indices are unsigned ADDR_W bits, so every index is in range. There is no wrap or overflow case.
//  - Back-to-back writes to one register: the last write wins.
//    A write to A followed by a read of A the next cycle returns the new data.
//  - No X propagation: registers are never uninitialised after the first reset.
// STRUCTURE
//  - Shared package regfile_pkg holds the defaults:
//    - WIDTH_DEF = 64
//    - NREGS_DEF = 32
//    - ZERO_IDX = NREGS_DEF - 1
//  - Sub-module decoder_n #(N_IN), ports enable, in[N_IN-1:0], out[2**N_IN-1:0]:
//    - Built recursively: a 1:2 stage drives the enables of two decoder_n #(N_IN-1) instances.
//    - Base case N_IN=1 is gates only.
//  - Storage: a generate loop of WIDTH-bit registers with enable and async reset.
//  - Read muxes: NREGS:1 muxes, one per port, plus a bypass or zero override stage.
// TESTING
//  1. Default params. Assert reset mid-cycle after loading reg5=0x1234.
//     -> ReadData1 (index 5) = 0 immediately, before any clk edge.
//  2. Write reg3 = 0xDEADBEEF_00000001 with RegWrite=1.
//     -> ReadData1 (index 3) = that value after the posedge; all other indices still read 0.
//  3. RegWrite=0, WriteRegister=7, WriteData=0xFF.
//     -> reg7 stays 0. With the decoder probed, out = 32'h0.
//  4. ZERO_REG=1: write 0xABCD to index 31.
//     -> both ports read index 31 as 0. With ZERO_REG=0, index 31 reads 0xABCD.
//  5. BYPASS=1: reg9 = 0x11; in the same cycle write 0x22 to reg9 while ReadRegister2=9.
//     -> ReadData2 = 0x22 before the edge. With BYPASS=0, ReadData2 = 0x11 before the edge and 0x22 after.
//  6. Sweep, for NREGS=8 and WIDTH=16: write i*0x0101 to each i in 0..6, then read all pairs (i, 7-i).
//     -> both ports match the model; index 7 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the parametrised register file.
//   WIDTH_DEF : default data width of each register
//   NREGS_DEF : default register count (power of 2, >= 2)
//   ZERO_IDX  : index of the hard-wired zero register at the default size
package regfile_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_IDX  = NREGS_DEF - 1;

endpackage : regfile_pkg

// File: rtl/regfile_nxw_decoder.sv
// decoder_n: N_IN:2**N_IN one-hot decoder with enable, built as a recursive tree.
//   enable : when 0, every output is 0
//   in     : binary index
//   out    : one-hot select, out[in] = enable
// The MSB of 'in' picks which half-size sub-decoder is enabled; N_IN=1 is the
// gate-level leaf.
module decoder_n
  import regfile_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                 enable,
  input  logic [N_IN-1:0]      in,
  output logic [2**N_IN-1:0]   out
);

  if (N_IN == 1) begin : g_leaf
    assign out[0] = enable & ~in[0];
    assign out[1] = enable &  in[0];
  end else begin : g_tree
    localparam int HALF = 2 ** (N_IN - 1);

    logic en_lo;
    logic en_hi;

    assign en_lo = enable & ~in[N_IN-1];
    assign en_hi = enable &  in[N_IN-1];

    decoder_n #(.N_IN(N_IN - 1)) u_lo (
      .enable (en_lo),
      .in     (in[N_IN-2:0]),
      .out    (out[HALF-1:0])
    );

    decoder_n #(.N_IN(N_IN - 1)) u_hi (
      .enable (en_hi),
      .in     (in[N_IN-2:0]),
      .out    (out[2*HALF-1:HALF])
    );
  end

endmodule : decoder_n

// File: rtl/regfile_nxw.sv
// regfile_nxw: NREGS x WIDTH register file, one synchronous write port and two
// combinational read ports.
//   clk                          : all state updates on posedge
//   reset                        : asynchronous, active-high; clears every register
//   RegWrite                     : write enable
//   WriteRegister / WriteData    : write index / data
//   ReadRegister1 / ReadRegister2: read indices
//   ReadData1 / ReadData2        : read data
// ZERO_REG=1 makes register NREGS-1 a constant 0; BYPASS=1 forwards WriteData
// to a port reading the register being written this cycle.
module regfile_nxw
  import regfile_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2
);

  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(NREGS - 1);

  logic [NREGS-1:0] we;
  logic [WIDTH-1:0] regs [NREGS];

  decoder_n #(.N_IN(ADDR_W)) u_dec (
    .enable (RegWrite),
    .in     (WriteRegister),
    .out    (we)
  );

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (ZERO_REG && (i == NREGS - 1)) begin : g_zero
      // Decoder still selects this slot; the write simply has nowhere to land.
      logic unused_we;
      assign unused_we = we[i];
      assign regs[i]   = '0;
    end else begin : g_store
      logic [WIDTH-1:0] q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else if (we[i]) begin
          q <= WriteData;
        end
      end
      assign regs[i] = q;
    end
  end

  // Zero register wins over bypass, bypass wins over stored value.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [ADDR_W-1:0] ra,
    input logic [WIDTH-1:0]  stored,
    input logic              wen,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd
  );
    logic [WIDTH-1:0] r;
    r = stored;
    if (ZERO_REG && (ra == ZIDX)) begin
      r = '0;
    end else if (BYPASS && wen && (ra == wa)) begin
      r = wd;
    end
    return r;
  endfunction

  always_comb begin
    ReadData1 = read_port(ReadRegister1, regs[ReadRegister1],
                          RegWrite, WriteRegister, WriteData);
  end

  always_comb begin
    ReadData2 = read_port(ReadRegister2, regs[ReadRegister2],
                          RegWrite, WriteRegister, WriteData);
  end

endmodule : regfile_nxw
